// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the SRAM port arbiter and future bus slaves.
//   - Access size encodings (SZ_*).
//   - Read-response source enum (rsp_src_e).
//   - be_gen(): byte-enable generation plus misalignment detection from an
//     access size and the two low byte-address bits.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_I    = 2'd1,
    RSP_D    = 2'd2
  } rsp_src_e;

  typedef struct packed {
    logic [3:0] be;
    logic       misaligned;
  } be_gen_t;

  // Byte lanes for an access of the given size at byte offset addr.
  // Reserved size and unaligned half/word accesses flag misaligned.
  function automatic be_gen_t be_gen(input logic [1:0] size, input logic [1:0] addr);
    be_gen_t r;
    r.be         = 4'b0000;
    r.misaligned = 1'b0;
    unique case (size)
      SZ_BYTE: r.be = 4'b0001 << addr;
      SZ_HALF: begin
        r.be         = addr[1] ? 4'b1100 : 4'b0011;
        r.misaligned = addr[0];
      end
      SZ_WORD: begin
        r.be         = 4'b1111;
        r.misaligned = |addr;
      end
      default: r.misaligned = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rdata_align.sv
// rdata_align: right-aligns and zero-extends a data-port read.
// Ports:
//   rdata_i [31:0] raw SRAM word
//   lane_i  [1:0]  byte offset of the access within the word
//   size_i  [1:0]  access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   rdata_o [31:0] shifted word with unused upper lanes cleared
module rdata_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;
  logic [3:0]  keep;

  assign shifted = rdata_i >> {lane_i, 3'b000};

  always_comb begin
    keep = 4'b1111;
    unique case (size_i)
      SZ_BYTE: keep = 4'b0001;
      SZ_HALF: keep = 4'b0011;
      default: keep = 4'b1111;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rdata_o[8*gi +: 8] = shifted[8*gi +: 8] & {8{keep[gi]}};
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM between the
// instruction-fetch (I) and data (D) ports of the core.
// Ports:
//   CLK, RESET                 clock, asynchronous active-high reset
//   IREQ/IADDR/IACK            fetch request, byte address, accept (comb)
//   IRVALID/IRDATA             fetch response one cycle after accept
//   DREQ/DADDR/DRW/DSIZE/DWDATA data request fields
//   DACK                       data accept (comb)
//   DRVALID/DRDATA             data read response, right-aligned
//   DERR                       one-cycle pulse for a rejected misaligned access
//   CSN/ADDR/WE/BE/DI/DO       SRAM port (DO valid one cycle after a read)
// Contested cycles alternate round-robin; an uncontested requester wins.
module sram_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IREQ,
  input  logic [31:0]       IADDR,
  output logic              IACK,
  output logic              IRVALID,
  output logic [31:0]       IRDATA,
  input  logic              DREQ,
  input  logic [31:0]       DADDR,
  input  logic              DRW,
  input  logic [1:0]        DSIZE,
  input  logic [31:0]       DWDATA,
  output logic              DACK,
  output logic              DRVALID,
  output logic [31:0]       DRDATA,
  output logic              DERR,
  output logic              CSN,
  output logic [ADDR_W-1:0] ADDR,
  output logic              WE,
  output logic [3:0]        BE,
  output logic [31:0]       DI,
  input  logic [31:0]       DO
);

  // Registers
  logic       last_gnt_q, last_gnt_d;   // 0 = I, 1 = D
  rsp_src_e   rsp_src_q, rsp_src_d;
  logic [1:0] rsp_lane_q, rsp_lane_d;
  logic [1:0] rsp_size_q, rsp_size_d;
  logic       err_q, err_d;
  logic [31:0] irdata_q, irdata_d;      // hold copies shown between responses
  logic [31:0] drdata_q, drdata_d;

  logic    i_pend, d_pend, gnt_i, gnt_d, d_access;
  be_gen_t d_be;
  logic [31:0] d_aligned;

  // Address bits outside the SRAM window and the fetch byte offset are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{IADDR[31:ADDR_W+2], IADDR[1:0], DADDR[31:ADDR_W+2]};

  rdata_align u_rdata_align (
    .rdata_i (DO),
    .lane_i  (rsp_lane_q),
    .size_i  (rsp_size_q),
    .rdata_o (d_aligned)
  );

  // Grant and SRAM drive
  always_comb begin
    // Requests are ignored while reset is held so no grant leaks out.
    i_pend   = IREQ & ~RESET;
    d_pend   = DREQ & ~RESET;
    // D wins when alone, or when contested and I had the previous grant.
    gnt_d    = d_pend & (~i_pend | ~last_gnt_q);
    gnt_i    = i_pend & ~gnt_d;
    d_be     = be_gen(DSIZE, DADDR[1:0]);
    // A misaligned D request is acknowledged but never reaches the SRAM.
    d_access = gnt_d & ~d_be.misaligned;

    IACK = gnt_i;
    DACK = gnt_d;
    CSN  = 1'b1;
    WE   = 1'b0;
    BE   = 4'b0000;
    ADDR = '0;
    DI   = '0;
    if (gnt_i) begin
      CSN  = 1'b0;
      BE   = 4'b1111;
      ADDR = IADDR[ADDR_W+1:2];
    end else if (d_access) begin
      CSN  = 1'b0;
      WE   = DRW;
      BE   = d_be.be;
      ADDR = DADDR[ADDR_W+1:2];
      unique case (DSIZE)
        SZ_BYTE: DI = {4{DWDATA[7:0]}};
        SZ_HALF: DI = {2{DWDATA[15:0]}};
        default: DI = DWDATA;
      endcase
    end
  end

  // Next state
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt_i)      last_gnt_d = 1'b0;
    else if (gnt_d) last_gnt_d = 1'b1;

    rsp_src_d  = RSP_NONE;
    rsp_lane_d = rsp_lane_q;
    rsp_size_d = rsp_size_q;
    if (gnt_i) begin
      rsp_src_d = RSP_I;
    end else if (d_access && !DRW) begin
      rsp_src_d  = RSP_D;
      rsp_lane_d = DADDR[1:0];
      rsp_size_d = DSIZE;
    end

    err_d    = gnt_d & d_be.misaligned;
    irdata_d = (rsp_src_q == RSP_I) ? DO : irdata_q;
    drdata_d = (rsp_src_q == RSP_D) ? d_aligned : drdata_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_gnt_q <= 1'b0;
      rsp_src_q  <= RSP_NONE;
      rsp_lane_q <= 2'b00;
      rsp_size_q <= SZ_BYTE;
      err_q      <= 1'b0;
      irdata_q   <= '0;
      drdata_q   <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rsp_src_q  <= rsp_src_d;
      rsp_lane_q <= rsp_lane_d;
      rsp_size_q <= rsp_size_d;
      err_q      <= err_d;
      irdata_q   <= irdata_d;
      drdata_q   <= drdata_d;
    end
  end

  // Response outputs: live SRAM data in the response cycle, held copy otherwise.
  assign IRVALID = (rsp_src_q == RSP_I);
  assign DRVALID = (rsp_src_q == RSP_D);
  assign IRDATA  = IRVALID ? DO : irdata_q;
  assign DRDATA  = DRVALID ? d_aligned : drdata_q;
  assign DERR    = err_q;

endmodule
